// File: rtl/counter_pkg.sv
// Shared constants for the LED counter: display width, KEY bit positions and
// the wrapping up/down step used by the count register.
package counter_pkg;

  localparam int LED_W     = 10;
  localparam int KEY_RST   = 0;
  localparam int KEY_PAUSE = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_FAST  = 3;

  // Wraps naturally at the register width (1023 -> 0 going up, 0 -> 1023 going down).
  function automatic logic [LED_W-1:0] step_count(input logic [LED_W-1:0] cnt,
                                                  input logic             down);
    return down ? (cnt - LED_W'(1)) : (cnt + LED_W'(1));
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides the board clock into a one-cycle count tick, every SLOW_DIV or
// FAST_DIV cycles depending on the rate select; holds its phase while disabled.
module counter_prescaler #(
  parameter int SLOW_DIV = 50_000_000,
  parameter int FAST_DIV = 5_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_fast,
  output logic o_tick
);

  localparam int TW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam logic [TW-1:0] SLOW_LAST = TW'(SLOW_DIV - 1);
  localparam logic [TW-1:0] FAST_LAST = TW'(FAST_DIV - 1);

  logic [TW-1:0] r_tick_cnt;
  logic [TW-1:0] w_last;
  logic          w_due;

  assign w_last = i_fast ? FAST_LAST : SLOW_LAST;
  // >= rather than == so a slow-to-fast switch past FAST_LAST fires at once.
  assign w_due  = (r_tick_cnt >= w_last);
  assign o_tick = i_enable & w_due;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tick_cnt <= '0;
    end else if (i_enable) begin
      if (w_due) r_tick_cnt <= '0;
      else       r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/counter_top.sv
// Board root: 10-bit LED counter with pause, direction and fast-rate keys.
// KEY[0] is a direct synchronous reset; KEY[3:1] pass through 2-flop synchronizers.
module counter_top
  import counter_pkg::*;
#(
  parameter int SLOW_DIV = 50_000_000,
  parameter int FAST_DIV = 5_000_000
) (
  input  logic             CLOCK_50,
  input  logic [3:0]       KEY,
  output logic [LED_W-1:0] LEDR
);

  logic [2:0]       r_key_p0;
  logic [2:0]       r_key_p1;
  logic [LED_W-1:0] r_count;
  logic             w_rst;
  logic             w_pause;
  logic             w_down;
  logic             w_fast;
  logic             w_tick;

  assign w_rst   = KEY[KEY_RST];
  assign w_pause = r_key_p1[KEY_PAUSE-1];
  assign w_down  = r_key_p1[KEY_DOWN-1];
  assign w_fast  = r_key_p1[KEY_FAST-1];

  // Stage p0 -> p1: synchronize the asynchronous control keys.
  always_ff @(posedge CLOCK_50) begin
    if (w_rst) begin
      r_key_p0 <= '0;
      r_key_p1 <= '0;
    end else begin
      r_key_p0 <= KEY[3:1];
      r_key_p1 <= r_key_p0;
    end
  end

  counter_prescaler #(
    .SLOW_DIV (SLOW_DIV),
    .FAST_DIV (FAST_DIV)
  ) u_prescaler (
    .i_clk    (CLOCK_50),
    .i_reset  (w_rst),
    .i_enable (~w_pause),
    .i_fast   (w_fast),
    .o_tick   (w_tick)
  );

  // Count register: updates on the tick edge itself, no extra output latency.
  always_ff @(posedge CLOCK_50) begin
    if (w_rst)       r_count <= '0;
    else if (w_tick) r_count <= step_count(r_count, w_down);
  end

  assign LEDR = r_count;

endmodule

// File: tb/tb_counter_top.sv
// Scoreboard bench for counter_top with SLOW_DIV=4, FAST_DIV=2: a cycle model
// pushes the expected LEDR per edge, popped and compared just after the edge.
module tb_counter_top;

  localparam int SLOW = 4;
  localparam int FAST = 2;

  logic       clk = 1'b0;
  logic [3:0] key = 4'b0001;
  logic [9:0] ledr;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int         m_cnt = 0;
  int         m_tc  = 0;
  logic [2:0] m_s1  = '0;
  logic [2:0] m_s2  = '0;
  int         sb_q[$];

  counter_top #(.SLOW_DIV(SLOW), .FAST_DIV(FAST)) dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .LEDR     (ledr)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: LEDR=%0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  div;
    bit  tick;
    if (key[0]) begin
      m_cnt = 0; m_tc = 0; m_s1 = '0; m_s2 = '0;
    end else begin
      div  = m_s2[2] ? FAST : SLOW;
      tick = 1'b0;
      if (!m_s2[0]) begin
        if (m_tc >= div - 1) begin tick = 1'b1; m_tc = 0; end
        else m_tc++;
      end
      if (tick) m_cnt = m_s2[1] ? (m_cnt + 1023) % 1024 : (m_cnt + 1) % 1024;
      m_s2 = m_s1;
      m_s1 = key[3:1];
    end
  endtask

  task automatic step(input int n);
    int exp;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      sb_q.push_back(m_cnt);
      #1;
      exp = sb_q.pop_front();
      chk_val("scoreboard", int'(ledr), exp);
    end
  endtask

  initial begin
    int budget;

    // reset, then run up to 0x155
    key = 4'b0001; step(2);
    chk_val("reset_initial", int'(ledr), 0);
    key = 4'b0000; step(SLOW * 341);
    chk_val("preload_155", int'(ledr), 'h155);

    // reset held 3 cycles clears on first sampling edge
    key = 4'b0001; step(1);
    chk_val("reset_first_edge", int'(ledr), 0);
    step(2);
    chk_val("reset_held", int'(ledr), 0);
    key = 4'b0000;
    step(3);  chk_val("release_e3", int'(ledr), 0);
    step(1);  chk_val("release_e4", int'(ledr), 1);
    step(3);  chk_val("release_e7", int'(ledr), 1);
    step(1);  chk_val("release_e8", int'(ledr), 2);
    step(4);  chk_val("release_e12", int'(ledr), 3);

    // wrap up: fast mode until 1023, then one more tick
    key = 4'b1000;
    budget = 4000;
    while (m_cnt != 1023 && budget > 0) begin step(1); budget--; end
    chk_val("reach_1023", int'(ledr), 1023);
    step(FAST);
    chk_val("wrap_up", int'(ledr), 0);

    // down and wrap
    key = 4'b0001; step(1);
    key = 4'b0100;
    step(3);  chk_val("down_e3", int'(ledr), 0);
    step(1);  chk_val("down_first", int'(ledr), 1023);
    step(4);  chk_val("down_second", int'(ledr), 1022);

    // pause mid-period at LEDR=5
    key = 4'b0001; step(1);
    key = 4'b0000; step(20);
    chk_val("pre_pause", int'(ledr), 5);
    key = 4'b0010; step(20);
    chk_val("paused_20", int'(ledr), 5);
    key = 4'b0000;
    step(3);  chk_val("resume_e3", int'(ledr), 5);
    step(1);  chk_val("resume_tick", int'(ledr), 6);

    // fast mode, then back to slow
    key = 4'b1000;
    step(3);  chk_val("fast_f3", int'(ledr), 7);
    step(2);  chk_val("fast_f5", int'(ledr), 8);
    step(2);  chk_val("fast_f7", int'(ledr), 9);
    step(1);
    key = 4'b0000;
    step(1);  chk_val("slow_g1", int'(ledr), 10);
    step(3);  chk_val("slow_g4", int'(ledr), 10);
    step(1);  chk_val("slow_g5", int'(ledr), 11);

    // reset on the edge of a due tick wins
    step(3);
    key = 4'b0001; step(1);
    chk_val("reset_vs_tick", int'(ledr), 0);

    // pause and down together
    key = 4'b0110; step(22);
    chk_val("pause_down_hold", int'(ledr), 0);
    key = 4'b0100;
    step(3);  chk_val("pause_down_r3", int'(ledr), 0);
    step(1);  chk_val("pause_down_r4", int'(ledr), 1023);

    // random key activity checked against the model
    for (int i = 0; i < 300; i++) begin
      key = 4'($urandom_range(0, 15));
      if (key[0] && ($urandom_range(0, 7) != 0)) key[0] = 1'b0;
      step(int'($urandom_range(1, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_top.md
# counter_top

Free-running 10-bit LED counter for the DE-series board simulation flow. A prescaler divides the 50 MHz board clock into a slow count tick, and the count is shown on LEDR[9:0]. KEY pushbuttons control reset, pause, direction and a fast-rate mode. The module is the design root and is instantiated positionally as (CLOCK_50, KEY, LEDR) by the board harness.

## Interface
Parameters:
- SLOW_DIV, 50_000_000: clock cycles per count step in normal mode (1 Hz); must be ≥ 2.
- FAST_DIV, 5_000_000: clock cycles per count step in fast mode (10 Hz); must be ≥ 1 and ≤ SLOW_DIV.

Ports (positional order CLOCK_50, KEY, LEDR):
- CLOCK_50  input  1  50 MHz board clock. One clock; all logic is on its rising edge.
- KEY  input  4  KEY[0] is the reset. Reset is synchronous and active-high. KEY[1] high pauses counting. KEY[2] high counts down. KEY[3] high selects the fast rate.
- LEDR  output  10  current count value, registered.

## Operation
- Internal state:
  - count[9:0]
  - tick_cnt, width ceil(log2(SLOW_DIV))
  - 2-flop synchronizers on KEY[3:1], giving pause_s, down_s and fast_s
- Reset: when KEY[0]=1 at a rising edge, the following are all cleared to 0 at that edge:
  - count, so LEDR=0
  - tick_cnt
  - all synchronizer flops
- KEY[0] is sampled directly and is not synchronized.
- Active divisor: DIV = fast_s ? FAST_DIV : SLOW_DIV.
- Prescaler:
  - If pause_s=1, tick_cnt holds and no tick is generated.
  - Otherwise, if tick_cnt ≥ DIV−1, the cycle is a tick and tick_cnt becomes 0.
  - Otherwise tick_cnt increments.
- Using ≥ in the compare makes a switch from slow to fast take effect immediately, even when tick_cnt is already past FAST_DIV−1.
- On a tick:
  - If down_s=0, count ← count+1 mod 1024, so 1023 wraps to 0.
  - If down_s=1, count ← count−1 mod 1024, so 0 wraps to 1023.
- Between ticks, count holds.
- LEDR = count at all times.
- Precedence when events coincide: reset > pause > tick. Direction and rate only choose how the tick is applied.
- Reset asserted in the middle of a prescale period discards the partial period. The first tick after release comes DIV cycles later.

## Timing
- Reset value of LEDR is 0 from the edge that samples KEY[0]=1.
- Changes on KEY[3:1] reach the control logic 2 cycles after they are sampled. Their effect is therefore visible on LEDR no earlier than the 3rd edge.
- Unpaused steady state: LEDR changes exactly once every DIV cycles.
  - The first change after reset release happens at the DIV-th rising edge with KEY[0]=0.
  - The LEDR update is registered on that same edge; there is no extra output latency.
- Pausing freezes both LEDR and tick_cnt. On resume, the partial period continues from where it stopped.
- A direction change does not reset tick_cnt. The next tick applies the new direction.
- KEY bounce is not filtered. Debounce is out of scope.

## Structure
- Shared package counter_pkg holds:
  - LED_W = 10
  - the KEY bit-index constants KEY_RST=0, KEY_PAUSE=1, KEY_DOWN=2, KEY_FAST=3
- Natural sub-module: prescaler.
  - Inputs: clk, reset, enable, fast.
  - Output: tick.
  - Parameters: SLOW_DIV, FAST_DIV.
- The top level contains the synchronizers, the up/down count register and the LEDR assignment.

## Test plan
Benches use SLOW_DIV=4 and FAST_DIV=2 unless stated otherwise.
- Reset: hold KEY=4'b0001 for 3 cycles from LEDR=0x155 → LEDR=0 at the first sampling edge. After release with KEY=0, LEDR steps 1, 2, 3 at release edges 4, 8, 12.
- Wrap up: preload to 1023 by counting, then one more tick → LEDR=0.
- Down and wrap: after reset, set KEY[2]=1 → the first tick gives LEDR=1023, the next gives 1022.
- Pause: with LEDR=5 mid-period, hold KEY[1]=1 for 20 cycles → LEDR stays 5. After release the tick arrives after the remaining cycles of the period plus the 2-cycle synchronizer delay, not a full new period.
- Fast mode: set KEY[3]=1 → after the synchronizer delay, ticks arrive every 2 cycles. Switching back to slow with tick_cnt=1 gives the next tick after 2 more cycles.
- Simultaneous events: assert KEY[0] on the same edge as a due tick → LEDR=0, not count+1. Assert KEY[1] and KEY[2] together → no change until KEY[1] is released.
